// File: rtl/burst_accum_pkg.sv
// Shared definitions for burst_accum: FSM encoding, default sizes, adder mode.
// Optional feature macro: BURST_ACCUM_SATURATE_EN (clamp the sum instead of wrapping).
package burst_accum_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int unsigned N_DEF = 32;
  localparam int unsigned K_DEF = 4;

`ifdef BURST_ACCUM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

endpackage

// File: rtl/burst_accum_accum_add.sv
// accum_add: N-bit unsigned add with carry out; optional clamp to all-ones on carry.
module accum_add #(
  parameter int unsigned N   = 32,
  parameter bit          SAT = 1'b0
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum_c,
  output logic         carry_c
);

  logic [N:0] raw;

  // One carry bit of growth only; the carry selects the clamp in saturate mode.
  assign raw     = {1'b0, a} + {1'b0, b};
  assign carry_c = raw[N];
  assign sum_c   = (SAT && raw[N]) ? {N{1'b1}} : raw[N-1:0];

endmodule

// File: rtl/burst_accum.sv
// burst_accum: reads K words from an upstream FIFO, sums them, presents the
// result with a valid/ready handshake and a sticky overflow flag.
// Optional feature macro: BURST_ACCUM_SATURATE_EN (sum clamps at all-ones).
module burst_accum
  import burst_accum_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned K = K_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_empty,
  output logic         fifo_rd_en,
  input  logic [N-1:0] fifo_dout,
  output logic [N-1:0] res_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_ovf
);

  localparam int unsigned CW = $clog2(K + 1);

  state_e        state_q, state_d;
  logic          run_q;
  logic          rd_q;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] captured_q;
  logic [N-1:0]  acc_q;
  logic          ovf_q;
  logic [N-1:0]  add_sum;
  logic          add_carry;
  logic          last_cap_c;
  logic          handshake_c;

  accum_add #(.N(N), .SAT(SAT_EN)) u_add (
    .a       (acc_q),
    .b       (fifo_dout),
    .sum_c   (add_sum),
    .carry_c (add_carry)
  );

  // Read strobe; run_q holds it off until the first edge after reset release.
  assign fifo_rd_en  = run_q && (state_q == ST_ACC) && !fifo_empty && (issued_q < CW'(K));
  assign last_cap_c  = rd_q && (captured_q == CW'(K - 1));
  assign handshake_c = res_valid && res_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_ACC;
    else      state_q <= state_d;
  end

  // Next-state: leave ACC on the K-th capture, leave HOLD on handshake.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_ACC) begin
      if (last_cap_c) state_d = ST_HOLD;
    end else begin
      if (handshake_c) state_d = ST_ACC;
    end
  end

  // Datapath: issue/capture counters, accumulator, result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      rd_q       <= 1'b0;
      issued_q   <= '0;
      captured_q <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      res_ovf    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      rd_q  <= fifo_rd_en;
      if (fifo_rd_en) issued_q <= issued_q + CW'(1);
      if (rd_q) begin
        acc_q      <= add_sum;
        ovf_q      <= ovf_q | add_carry;
        captured_q <= captured_q + CW'(1);
      end
      if (last_cap_c) begin
        res_data  <= add_sum;
        res_ovf   <= ovf_q | add_carry;
        res_valid <= 1'b1;
      end
      // A handshake only happens in HOLD, where no capture can be pending.
      if (handshake_c) begin
        acc_q      <= '0;
        issued_q   <= '0;
        captured_q <= '0;
        ovf_q      <= 1'b0;
        res_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_burst_accum.sv
// Directed bench for burst_accum at N=8, K=4 with a small upstream FIFO model.
module tb_burst_accum;

  localparam int unsigned N = 8;
  localparam int unsigned K = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [N-1:0] fifo_dout;
  logic [N-1:0] res_data;
  logic         res_valid;
  logic         res_ready;
  logic         res_ovf;

  int checks = 0;
  int errors = 0;

  // FIFO model state: main block writes mem/wr_ptr, model owns rd_ptr.
  logic [N-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit force_empty = 1'b0;

  // Monitor state.
  int cyc = 0;
  int rd_cnt = 0;
  int bad_rd = 0;
  int rd_hist [0:3];

  burst_accum #(.N(N), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ovf    (res_ovf)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;

  // FIFO data one cycle after the read strobe, plus read bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_dout  <= mem[rd_ptr[5:0]];
      rd_ptr     <= rd_ptr + 1;
      rd_cnt     <= rd_cnt + 1;
      rd_hist[0] <= rd_hist[1];
      rd_hist[1] <= rd_hist[2];
      rd_hist[2] <= rd_hist[3];
      rd_hist[3] <= cyc;
      if (fifo_empty) bad_rd <= bad_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Waits (bounded) for res_valid at a negedge; returns the cycle it was seen.
  task automatic wait_valid(input string tag, input bit toggle, output int vcyc);
    bit seen;
    seen = 1'b0;
    vcyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (toggle) force_empty = !force_empty;
      @(negedge clk);
      if (res_valid === 1'b1) begin
        seen = 1'b1;
        vcyc = cyc;
      end
    end
    force_empty = 1'b0;
    if (!seen) chk({tag, "_timeout"}, 32'(res_valid), 32'd1);
  endtask

  initial begin
    int vc;
    int start;
    fifo_dout = '0;
    res_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) rd_hist[i] = 0;

    // Reset with a non-empty FIFO: no reads, all outputs zero.
    push(8'd1); push(8'd2); push(8'd3); push(8'd4);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_ovf", 32'(res_ovf), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_no_rd", 32'(fifo_rd_en), 32'd0);

    // Burst 1,2,3,4: consecutive reads, sum 10, latency 2.
    wait_valid("b1", 1'b0, vc);
    chk("b1_data", 32'(res_data), 32'd10);
    chk("b1_ovf", 32'(res_ovf), 32'd0);
    chk("b1_reads", 32'(rd_cnt), 32'd4);
    chk("b1_consec", 32'(rd_hist[3] - rd_hist[0]), 32'd3);
    chk("b1_latency", 32'(vc - rd_hist[3]), 32'd2);
    @(negedge clk);
    chk("b1_valid_drop", 32'(res_valid), 32'd0);

    // Overflow burst 100,100,100,10.
    push(8'd100); push(8'd100); push(8'd100); push(8'd10);
    wait_valid("b2", 1'b0, vc);
`ifdef BURST_ACCUM_SATURATE_EN
    chk("b2_data", 32'(res_data), 32'd255);
`else
    chk("b2_data", 32'(res_data), 32'd54);
`endif
    chk("b2_ovf", 32'(res_ovf), 32'd1);
    @(negedge clk);

    // Empty toggling every cycle: 5,6,7,8 -> 26, reads only when non-empty.
    start = rd_cnt;
    push(8'd5); push(8'd6); push(8'd7); push(8'd8);
    wait_valid("b3", 1'b1, vc);
    chk("b3_data", 32'(res_data), 32'd26);
    chk("b3_ovf", 32'(res_ovf), 32'd0);
    chk("b3_reads", 32'(rd_cnt - start), 32'd4);
    chk("b3_bad_rd", 32'(bad_rd), 32'd0);
    @(negedge clk);

    // Backpressure: ready low 5 cycles with FIFO non-empty.
    res_ready = 1'b0;
    push(8'd1); push(8'd2); push(8'd3); push(8'd4);
    push(8'd10); push(8'd20); push(8'd30); push(8'd40);
    wait_valid("b4", 1'b0, vc);
    chk("b4_data", 32'(res_data), 32'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b4_hold_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("b4_hold_valid", 32'(res_valid), 32'd1);
      chk("b4_hold_data", 32'(res_data), 32'd10);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("b4_valid_drop", 32'(res_valid), 32'd0);
    wait_valid("b5", 1'b0, vc);
    chk("b5_data", 32'(res_data), 32'd100);
    chk("b5_ovf", 32'(res_ovf), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);

    // Reset after two captures of 9,9 discards the partial sum.
    start = rd_cnt;
    push(8'd9); push(8'd9);
    for (int i = 0; i < 40 && rd_cnt != start + 2; i++) @(negedge clk);
    chk("b6_two_reads", 32'(rd_cnt - start), 32'd2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(8'd1); push(8'd1); push(8'd1); push(8'd1);
    repeat (2) @(negedge clk);
    chk("b6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("b6_rst_valid", 32'(res_valid), 32'd0);
    chk("b6_rst_data", 32'(res_data), 32'd0);
    chk("b6_rst_ovf", 32'(res_ovf), 32'd0);
    rst = 1'b1;
    wait_valid("b6", 1'b0, vc);
    chk("b6_data", 32'(res_data), 32'd4);
    chk("b6_ovf", 32'(res_ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
